fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream and downstream of the instruction cache.
- Owns the fetch PC and drives both the current and next PC into the cache, so the cache's synchronous banks read the correct line.
- Captures each cache hit (pc, instruction) into a small FIFO that decouples fetch from decode.
- Handles redirects (branch/jump/exception) by flushing the FIFO and restarting fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 0, fetch address after reset; must be `ADDR_WIDTH wide and word aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- i_cache_valid  in  1  cache hit for o_pc_current this cycle
- i_cache_data  in  `DATA_WIDTH  instruction word for o_pc_current
- o_pc_current  out  `ADDR_WIDTH  address the cache is looking up this cycle (registered)
- o_pc_next  out  `ADDR_WIDTH  address for the next cycle (combinational)
- i_redirect_valid  in  1  redirect request
- i_redirect_pc  in  `ADDR_WIDTH  redirect target
- o_inst_valid  out  1  FIFO head valid
- o_inst_data  out  `DATA_WIDTH  head instruction
- o_inst_pc  out  `ADDR_WIDTH  head PC
- i_inst_ready  in  1  consumer accepts head this cycle

Behaviour:
- Reset (rst_n=0 at posedge): pc_current<=RESET_PC; rd_ptr, wr_ptr, count<=0; o_inst_valid=0. o_inst_data and o_inst_pc are don't-care while invalid.
- full = (count==DEPTH); enq = i_cache_valid & ~full & ~i_redirect_valid; deq = o_inst_valid & i_inst_ready.
- o_pc_next: i_redirect_valid ? {i_redirect_pc[ADDR-1:2],2'b00} : enq ? pc_current+4 : pc_current. Addition wraps modulo 2^`ADDR_WIDTH.
- Invariant: pc_current at cycle t+1 equals o_pc_next at cycle t, always, including during reset deassertion. During reset, o_pc_next=RESET_PC.
- While the cache misses (i_cache_valid=0), pc_current holds. o_pc_next equals pc_current, so the cache re-reads the same line after refill.
- Enqueue writes {pc_current, i_cache_data} at wr_ptr; wr_ptr increments modulo DEPTH.
- Dequeue increments rd_ptr modulo DEPTH.
- count updates by +enq-deq. Simultaneous enq/deq leaves count unchanged.
- Full: enq is blocked even if deq occurs the same cycle (no pop-through). The PC stalls and the cache keeps hitting the same address.
- Empty: o_inst_valid=0; i_inst_ready is ignored.
- Latency: a hit at cycle t appears on o_inst_* at t+1 at the earliest (registered FIFO).
- Redirect (highest priority):
  - At the posedge: count, rd_ptr, wr_ptr<=0 and pc_current<=aligned target.
  - The same-cycle cache data is discarded.
  - A same-cycle dequeue is still considered consumed by the consumer, but the FIFO state is cleared regardless.
  - o_inst_valid=0 in the following cycle.
- Back-to-back redirects: each overrides the previous; no entry is enqueued in between.
- Reset mid-operation: all in-flight entries are lost. No other state is retained.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, i_cache_valid=1 and i_redirect_valid=0, o_inst_valid=1 and o_inst_data/o_inst_pc come combinationally from i_cache_data/pc_current.
  - If i_inst_ready=1 the word is consumed and not enqueued (PC still advances).
  - Otherwise it is enqueued normally.
  - Hit-to-consumer latency becomes 0 cycles.
- Undefined: output comes only from FIFO registers, with 1-cycle minimum latency.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t packed struct {pc `ADDR_WIDTH, instr `DATA_WIDTH}
  - localparam FETCH_PTR_W = $clog2(DEPTH)
  - default RESET_PC constant
- Sub-module fetch_fifo:
  - generic synchronous FIFO of fetch_entry_t with push/pop/flush/full/empty/count.
  - fetch_queue holds PC logic, enq/deq gating, redirect and bypass.

Test Plan:
- Reset, then hits every cycle with i_inst_ready=1: o_pc_current goes 0,4,8,C; o_inst_pc goes 0,4,8 from cycle 1 with matching data; count stays ≤1.
- Miss at PC 0x10 for 6 cycles, then hit: o_pc_current and o_pc_next hold 0x10 throughout; exactly one entry with pc 0x10 is enqueued after the hit; no duplicates.
- i_inst_ready=0 with continuous hits, DEPTH=4: exactly 4 entries (0x0,0x4,0x8,0xC); PC stalls at 0x10. Then one pop with a hit in the same cycle: no enqueue that cycle; 0x10 is enqueued next cycle.
- FIFO holding 3 entries, redirect to 0x123 with a hit in the same cycle: next cycle o_inst_valid=0, o_pc_current=0x120; first enqueued entry has pc 0x120.
- Run 20 cycles with random ready and random hits: wr_ptr and rd_ptr wrap past DEPTH; the sequence of PCs delivered to the consumer is strictly +4 with no loss or duplication.
- With FETCH_QUEUE_BYPASS_EN, empty FIFO, hit at 0x40 with i_inst_ready=1: o_inst_valid=1 and o_inst_pc=0x40 in the same cycle; count stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Address/data widths come from `ADDR_WIDTH / `DATA_WIDTH (default 32).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package fetch_pkg;
    localparam int FETCH_ADDR_W = `ADDR_WIDTH;
    localparam int FETCH_DATA_W = `DATA_WIDTH;
    localparam int FETCH_DEPTH  = 4;
    localparam int FETCH_PTR_W  = $clog2(FETCH_DEPTH);

    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [FETCH_ADDR_W-1:0] align_pc(input logic [FETCH_ADDR_W-1:0] pc);
        return {pc[FETCH_ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Cache-side, redirect and consumer signals of the fetch queue.
// master drives the i_* inputs (environment); slave is the fetch queue itself.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic                    i_cache_valid;
    logic [FETCH_DATA_W-1:0] i_cache_data;
    logic [FETCH_ADDR_W-1:0] o_pc_current;
    logic [FETCH_ADDR_W-1:0] o_pc_next;
    logic                    i_redirect_valid;
    logic [FETCH_ADDR_W-1:0] i_redirect_pc;
    logic                    o_inst_valid;
    logic [FETCH_DATA_W-1:0] o_inst_data;
    logic [FETCH_ADDR_W-1:0] o_inst_pc;
    logic                    i_inst_ready;

    modport master (
        output i_cache_valid, i_cache_data, i_redirect_valid, i_redirect_pc, i_inst_ready,
        input  o_pc_current, o_pc_next, o_inst_valid, o_inst_data, o_inst_pc
    );

    modport slave (
        input  i_cache_valid, i_cache_data, i_redirect_valid, i_redirect_pc, i_inst_ready,
        output o_pc_current, o_pc_next, o_inst_valid, o_inst_data, o_inst_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; registered head output.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count gates validity, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, captures cache hits into a FIFO, handles redirects.
// Optional `FETCH_QUEUE_BYPASS_EN: zero-latency hit-to-consumer path when the FIFO is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                      DEPTH    = FETCH_DEPTH,
    parameter logic [FETCH_ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    localparam int                     CNT_W    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    fetch_queue_if.slave fq
);
    logic [FETCH_ADDR_W-1:0] pc_current_q, pc_next_d;
    fetch_entry_t            head, wentry;
    logic                    fifo_full, fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    hit_ok, bypass, bypass_take, enq, deq;

    always_comb begin
        hit_ok = fq.i_cache_valid & ~fifo_full & ~fq.i_redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = fq.i_cache_valid & ~fq.i_redirect_valid & fifo_empty;
`else
        bypass = 1'b0;
`endif
        bypass_take = bypass & fq.i_inst_ready;
        enq         = hit_ok & ~bypass_take;
        deq         = ~fifo_empty & fq.i_inst_ready;

        // Reset is folded into the next-PC mux so pc_current(t+1) == o_pc_next(t) always holds.
        if (!rst_n)                   pc_next_d = RESET_PC;
        else if (fq.i_redirect_valid) pc_next_d = align_pc(fq.i_redirect_pc);
        else if (hit_ok)              pc_next_d = pc_current_q + FETCH_ADDR_W'(4);
        else                          pc_next_d = pc_current_q;
    end

    always_ff @(posedge clk) begin
        pc_current_q <= pc_next_d;
    end

    assign wentry = '{pc: pc_current_q, instr: fq.i_cache_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (enq),
        .pop_i   (deq),
        .flush_i (fq.i_redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fq.o_pc_current = pc_current_q;
    assign fq.o_pc_next    = pc_next_d;
    assign fq.o_inst_valid = (fifo_count != '0) | bypass;
    assign fq.o_inst_pc    = fifo_empty ? pc_current_q    : head.pc;
    assign fq.o_inst_data  = fifo_empty ? fq.i_cache_data : head.instr;
endmodule
